// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: transmitter state encoding, data width and the
// default baud divider so the transmitter and receiver agree on bit timing.
package uart_defs;

    localparam int UART_DATA_W = 8;

    // 50 MHz system clock / 115200 baud
    localparam int UART_CLK_DIV = 434;

    typedef enum logic [2:0] {
        UTX_IDLE   = 3'd0,
        UTX_START  = 3'd1,
        UTX_DATA   = 3'd2,
        UTX_PARITY = 3'd3,
        UTX_STOP   = 3'd4
    } utx_state_t;

    // Even parity: the parity bit makes the total count of ones even
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-rate counter: counts 0..CLK_DIV-1 while running and flags the last
// cycle of each bit period. Clear holds the count at zero.
module uart_baud_cnt #(
    parameter int CLK_DIV = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic bit_tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    assign bit_tick = run && !clear && (count == LAST);

    // Count cycles within a bit, wrapping to zero on the bit boundary
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: LSB-first frames with optional even parity and one
// or two stop bits, plus a one-byte holding buffer so the next byte can be
// accepted while the current frame is still shifting out.
module uart_tx
    import uart_defs::*;
#(
    parameter int CLK_DIV   = UART_CLK_DIV,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   txd,
    output logic                   tx_busy,
    output logic                   tx_done
);

    utx_state_t             state_q, state_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [UART_DATA_W-1:0] buf_q, buf_d;
    logic                   buf_full_q, buf_full_d;

    logic bit_tick;
    logic accept;
    logic last_stop;
    logic frame_end;
    logic is_idle;

    assign is_idle   = (state_q == UTX_IDLE);
    assign tx_ready  = !buf_full_q;
    assign accept    = tx_valid && tx_ready;
    assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));
    assign frame_end = (state_q == UTX_STOP) && last_stop && bit_tick;
    assign tx_done   = frame_end;
    assign tx_busy   = !is_idle;

    uart_baud_cnt #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (is_idle),
        .run     (!is_idle),
        .bit_tick(bit_tick)
    );

    // Next-state logic: frame sequencing, shift register and holding buffer
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;

        case (state_q)
            UTX_IDLE: begin
                if (accept) begin
                    shift_d  = tx_data;
                    parity_d = even_parity(tx_data);
                    state_d  = UTX_START;
                end
            end
            UTX_START: begin
                if (bit_tick) begin
                    state_d   = UTX_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            UTX_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        stop_idx_d = 1'b0;
                        state_d    = (PARITY_EN != 0) ? UTX_PARITY : UTX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            UTX_PARITY: begin
                if (bit_tick) begin
                    stop_idx_d = 1'b0;
                    state_d    = UTX_STOP;
                end
            end
            UTX_STOP: begin
                if (bit_tick) begin
                    if (last_stop) begin
                        // Chain the next frame with no idle gap when a byte is waiting
                        if (buf_full_q) begin
                            shift_d    = buf_q;
                            parity_d   = even_parity(buf_q);
                            buf_full_d = 1'b0;
                            state_d    = UTX_START;
                        end else if (accept) begin
                            shift_d  = tx_data;
                            parity_d = even_parity(tx_data);
                            state_d  = UTX_START;
                        end else begin
                            state_d = UTX_IDLE;
                        end
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = UTX_IDLE;
            end
        endcase

        // A byte offered mid-frame parks in the holding buffer
        if (accept && !is_idle && !frame_end) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    // State register; reset aborts any frame and drops the buffered byte
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= UTX_IDLE;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end

    // Serial line level decoded from the current state
    always_comb begin
        txd = 1'b1;
        case (state_q)
            UTX_START:  txd = 1'b0;
            UTX_DATA:   txd = shift_q[0];
            UTX_PARITY: txd = parity_q;
            default:    txd = 1'b1;
        endcase
    end

endmodule
